// File: rtl/sample_readout_seq_pkg.sv
// sample_readout_seq_pkg: shared state encoding, default geometry and byte width
// for the sample RAM readout sequencer.
package sample_readout_seq_pkg;

    localparam int DEF_RAM_WIDTH = 10;
    localparam int DEF_NCHAN     = 4;
    localparam int BYTE_W        = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAITRDY,
        SELCH,
        ADDR,
        READ,
        SEND,
        CSUM,
        FIN
    } state_e;

    // Width of a channel index; never zero so a single-channel build still has a port.
    function automatic int chan_w(input int nchan);
        return (nchan > 1) ? $clog2(nchan) : 1;
    endfunction

endpackage

// File: rtl/sample_readout_seq_if.sv
// sample_readout_seq_if: sample RAM read port plus the valid/ready byte stream
// towards the host transmit path.
interface sample_readout_seq_if import sample_readout_seq_pkg::*; #(
    parameter int RAM_WIDTH = DEF_RAM_WIDTH,
    parameter int NCHAN     = DEF_NCHAN
);

    logic                    rden;
    logic [RAM_WIDTH-1:0]    rdaddress;
    logic [BYTE_W*NCHAN-1:0] rd_data;
    logic [BYTE_W-1:0]       out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output rden,
        output rdaddress,
        input  rd_data,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  rden,
        input  rdaddress,
        output rd_data,
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/sample_readout_seq_chan_pick.sv
// readout_chan_pick: lowest channel at or above cur whose mask bit is set;
// none_o flags that no such channel remains.
module readout_chan_pick import sample_readout_seq_pkg::*; #(
    parameter int NCHAN = DEF_NCHAN,
    parameter int CHW   = chan_w(DEF_NCHAN)
) (
    input  logic [NCHAN-1:0] mask_i,
    input  logic [CHW:0]     cur_i,
    output logic [CHW-1:0]   ch_o,
    output logic             none_o
);

    always_comb begin
        ch_o   = '0;
        none_o = 1'b1;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (mask_i[i] && (CHW + 1)'(i) >= cur_i) begin
                ch_o   = CHW'(i);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sample_readout_seq.sv
// sample_readout_seq: after a capture completes, streams the selected channels' samples
// from the circular RAM (pre-trigger origin first), then pulses done/rearm.
// Define READOUT_CHECKSUM_EN to append the 8-bit sum of all sent sample bytes as a trailer.
module sample_readout_seq import sample_readout_seq_pkg::*; #(
    parameter int RAM_WIDTH = DEF_RAM_WIDTH,
    parameter int NCHAN     = DEF_NCHAN
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start_i,
    input  logic                 data_ready_i,
    input  logic [RAM_WIDTH-1:0] trig_addr_i,
    input  logic [RAM_WIDTH-1:0] pretrig_i,
    input  logic [RAM_WIDTH-1:0] nsmp_i,
    input  logic [NCHAN-1:0]     chan_mask_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 rearm_o,
    sample_readout_seq_if.master bus
);

    localparam int CHW = chan_w(NCHAN);

    state_e               state_q;
    logic [RAM_WIDTH-1:0] base_q;
    logic [RAM_WIDTH-1:0] nsmp_q;
    logic [RAM_WIDTH-1:0] idx_q;
    logic [RAM_WIDTH-1:0] rdaddress_q;
    logic [NCHAN-1:0]     mask_q;
    logic [CHW:0]         cur_q;
    logic [CHW-1:0]       ch_q;
    logic [CHW-1:0]       pick_ch;
    logic                 pick_none;
    logic [BYTE_W-1:0]    out_data_q;
    logic                 rden_q;
    logic                 out_valid_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 rearm_q;
`ifdef READOUT_CHECKSUM_EN
    logic [BYTE_W-1:0]    csum_q;
`endif

    readout_chan_pick #(
        .NCHAN (NCHAN),
        .CHW   (CHW)
    ) u_pick (
        .mask_i (mask_q),
        .cur_i  (cur_q),
        .ch_o   (pick_ch),
        .none_o (pick_none)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            base_q      <= '0;
            nsmp_q      <= '0;
            idx_q       <= '0;
            rdaddress_q <= '0;
            mask_q      <= '0;
            cur_q       <= '0;
            ch_q        <= '0;
            out_data_q  <= '0;
            rden_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rearm_q     <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            rden_q  <= 1'b0;
            done_q  <= 1'b0;
            rearm_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        base_q  <= trig_addr_i - pretrig_i;
                        nsmp_q  <= nsmp_i;
                        mask_q  <= chan_mask_i;
                        busy_q  <= 1'b1;
                        state_q <= WAITRDY;
`ifdef READOUT_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                    end
                end
                WAITRDY: begin
                    if (data_ready_i) begin
                        cur_q   <= '0;
                        state_q <= SELCH;
                    end
                end
                // nsmp of zero is treated like an empty mask so idx never has to count down from it
                SELCH: begin
                    if (pick_none || nsmp_q == '0) begin
`ifdef READOUT_CHECKSUM_EN
                        out_data_q  <= csum_q;
                        out_valid_q <= 1'b1;
                        state_q     <= CSUM;
`else
                        done_q      <= 1'b1;
                        rearm_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= FIN;
`endif
                    end else begin
                        ch_q        <= pick_ch;
                        idx_q       <= '0;
                        rdaddress_q <= base_q;
                        rden_q      <= 1'b1;
                        state_q     <= ADDR;
                    end
                end
                ADDR: state_q <= READ;
                READ: begin
                    out_data_q  <= bus.rd_data[ch_q*BYTE_W +: BYTE_W];
                    out_valid_q <= 1'b1;
                    state_q     <= SEND;
                end
                SEND: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        idx_q       <= idx_q + 1'b1;
`ifdef READOUT_CHECKSUM_EN
                        csum_q      <= csum_q + out_data_q;
`endif
                        if (idx_q == nsmp_q - 1'b1) begin
                            cur_q   <= (CHW + 1)'(ch_q) + 1'b1;
                            state_q <= SELCH;
                        end else begin
                            rdaddress_q <= base_q + idx_q + 1'b1;
                            rden_q      <= 1'b1;
                            state_q     <= ADDR;
                        end
                    end
                end
`ifdef READOUT_CHECKSUM_EN
                CSUM: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        rearm_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= FIN;
                    end
                end
`endif
                FIN: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rden      = rden_q;
    assign bus.rdaddress = rdaddress_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign rearm_o       = rearm_q;

endmodule

// File: doc/sample_readout_seq.md
Name: sample_readout_seq

Overview:
- Downstream consumer of the ADC acquisition stage.
- Waits for a completed capture (data_ready) and reads the circular sample RAM starting at the pre-trigger origin.
- Streams the selected channels' bytes to the host transmit path over a valid/ready byte interface.
- Afterwards pulses a re-arm strobe into the acquisition stage's startTrigger input.

Parameters:
- RAM_WIDTH, 10, sample RAM address width; depth 2^RAM_WIDTH
- NCHAN, 4, number of 8-bit ADC channels in the RAM read word

Ports:
- clk  in  1  system clock (same as acquisition "clk")
- rstn  in  1  synchronous active-low reset
- start  in  1  one-cycle readout request from command decoder
- data_ready  in  1  capture complete, from acquisition stage
- trig_addr  in  RAM_WIDTH  write address latched at trigger
- pretrig  in  RAM_WIDTH  pre-trigger sample count
- nsmp  in  RAM_WIDTH  samples per channel to send
- chan_mask  in  NCHAN  channels to send, bit i = channel i
- rden  out  1  RAM read enable
- rdaddress  out  RAM_WIDTH  RAM read address
- rd_data  in  8*NCHAN  RAM read word; channel i at bits [8i+7:8i]; valid 1 cycle after rden
- out_data  out  8  streamed byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts byte
- busy  out  1  high from start acceptance to done
- done  out  1  one-cycle pulse at end of readout
- rearm  out  1  one-cycle pulse, coincident with done, to startTrigger

Behaviour:
- Reset: rden, out_valid, busy, done and rearm are 0; rdaddress and out_data are 0; state is IDLE.
- Sampled inputs: trig_addr, pretrig, nsmp and chan_mask are latched when start is accepted in IDLE. start is ignored in any other state.
- Base address: base = trig_addr - pretrig, mod 2^RAM_WIDTH.
- Sample address: base + idx, mod 2^RAM_WIDTH, wrapping silently.
- States:
  - IDLE: start -> WAITRDY, busy=1.
  - WAITRDY: data_ready=1 -> SELCH. Data_ready already high at start proceeds the next cycle.
  - SELCH: find the lowest channel ch >= cur with its mask bit set; -> ADDR with idx=0. If none remain -> (CSUM if enabled) else FIN. A mask of 0 or nsmp=0 sends no sample bytes.
  - ADDR: rdaddress=base+idx, rden=1 for exactly one cycle -> READ.
  - READ: capture rd_data byte ch into out_data, out_valid=1 -> SEND.
  - SEND: on out_valid && out_ready: out_valid=0, idx++. If idx==nsmp-1 was just sent: cur=ch+1 -> SELCH. Otherwise -> ADDR.
  - FIN: done=1, rearm=1, busy=0 for one cycle -> IDLE.
- Handshake: out_data is stable and out_valid stays high until out_ready. A byte transfers on the cycle where both are high.
- Throughput: max 1 byte per 3 cycles.
- Ordering: channel ascending; within a channel, oldest sample first (pre-trigger origin first).
- data_ready falling mid-readout: ignored; the readout completes.
- rstn low mid-readout: return to IDLE next edge, drop out_valid, no done or rearm.
- Counters: idx and nsmp comparison are RAM_WIDTH bits wide; nsmp=2^RAM_WIDTH-1 is the max per channel.

Optional Feature:
- Macro: READOUT_CHECKSUM_EN.
- Defined: after the last channel, the CSUM state sends one extra byte, the 8-bit sum mod 256 of all sample bytes sent in this readout. It uses the same handshake, then -> FIN. The sum is cleared on start acceptance.
- Undefined: there is no CSUM state or accumulator, and SELCH goes straight to FIN.

Decomposition:
- Shared package holds:
  - state enum (IDLE, WAITRDY, SELCH, ADDR, READ, SEND, CSUM, FIN);
  - RAM_WIDTH default;
  - NCHAN;
  - byte width constant 8.
- One natural sub-module, readout_chan_pick: combinational lowest-set-bit search of chan_mask at or above cur. Outputs channel index and a none flag.

Test Plan:
- Wrap: trig_addr=5, pretrig=10, nsmp=4, mask=0001, RAM[i]=i&0xFF, out_ready=1 -> bytes FB,FC,FD,FE; rdaddress sequence 1019..1022; then done and rearm pulse once.
- Mask skip: mask=1010, nsmp=2, base=0, ch1 byte=0x11, ch3 byte=0x33 -> 11,11,33,33 and no ch0/ch2 bytes.
- Backpressure: out_ready low for 5 cycles at byte 2 -> out_valid held, out_data unchanged, no extra rden until accept.
- Empty: mask=0 or nsmp=0 -> no out_valid ever; done/rearm pulse 2 cycles after data_ready.
- Reset mid-stream: rstn low at 3rd byte -> next cycle out_valid=0, busy=0; no done; a new start works normally.
- Checksum (READOUT_CHECKSUM_EN): bytes 0xFF,0x02 -> trailer 0x01; without macro, no trailer byte.
